// File: rtl/mandel_depth_engine_if.sv
// Job/result handshake bundle for mandel_depth_engine.
// The master side issues jobs and consumes results; the slave side is the engine.
interface mandel_depth_engine_if #(
    parameter int unsigned WORD_LENGTH = 32,
    parameter int unsigned ITER_W      = 11
);
    logic                          in_valid;
    logic                          in_ready;
    logic [10:0]                   in_x;
    logic [10:0]                   in_y;
    logic signed [WORD_LENGTH-1:0] re_c;
    logic signed [WORD_LENGTH-1:0] im_c;
    logic signed [WORD_LENGTH-1:0] re_z0;
    logic signed [WORD_LENGTH-1:0] im_z0;
    logic                          julia_mode;
    logic [ITER_W-1:0]             max_iter;
    logic                          abort;
    logic                          out_valid;
    logic                          out_ready;
    logic [10:0]                   out_x;
    logic [10:0]                   out_y;
    logic [ITER_W-1:0]             out_depth;
    logic                          out_escaped;

    modport master (
        output in_valid, in_x, in_y, re_c, im_c, re_z0, im_z0, julia_mode, max_iter, abort,
        output out_ready,
        input  in_ready, out_valid, out_x, out_y, out_depth, out_escaped
    );

    modport slave (
        input  in_valid, in_x, in_y, re_c, im_c, re_z0, im_z0, julia_mode, max_iter, abort,
        input  out_ready,
        output in_ready, out_valid, out_x, out_y, out_depth, out_escaped
    );
endinterface

// File: rtl/mandel_depth_engine.sv
// Fixed-point Mandelbrot/Julia escape-depth engine, one job at a time.
// Each iteration takes three cycles: multiply, accumulate, update/decide.
module mandel_depth_engine #(
    parameter int unsigned WORD_LENGTH = 32,
    parameter int unsigned FRAC        = 28,
    parameter int unsigned ITER_W      = 11
) (
    input logic                  sysclk,
    input logic                  reset_n,
    mandel_depth_engine_if.slave bus
);

    localparam int unsigned PW = 2 * WORD_LENGTH;
    localparam int unsigned MW = PW + 1;
    // 4.0 expressed in the product scale (2*FRAC fractional bits)
    localparam logic signed [MW-1:0] ESC_LIMIT = MW'(1) << (2 * FRAC + 2);

    typedef enum logic [2:0] {StIdle, StMult, StAccum, StUpdate, StHold} state_e;

    state_e                        state_q, state_d;
    logic [10:0]                   x_q, y_q;
    logic [ITER_W-1:0]             max_iter_q, depth_q;
    logic signed [WORD_LENGTH-1:0] re_c_q, im_c_q;
    logic signed [WORD_LENGTH-1:0] re_q, im_q, re_nx_q, im_nx_q;
    logic signed [PW-1:0]          rr_q, ii_q, ri_q;
    logic signed [MW-1:0]          mag_q;
    logic                          out_valid_q, out_escaped_q;
    logic [10:0]                   out_x_q, out_y_q;
    logic [ITER_W-1:0]             out_depth_q;

    logic                 accept, escape, limit;
    logic signed [PW-1:0] re_ext, im_ext, re_sum, im_sum;

    assign bus.in_ready = reset_n && (state_q == StIdle);
    assign accept       = bus.in_valid && bus.in_ready;
    assign escape       = mag_q > ESC_LIMIT;
    assign limit        = depth_q == max_iter_q;

    assign re_ext = PW'(re_q);
    assign im_ext = PW'(im_q);
    assign re_sum = (rr_q >>> FRAC) - (ii_q >>> FRAC) + PW'(re_c_q);
    assign im_sum = (ri_q >>> (FRAC - 1)) + PW'(im_c_q);

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (accept) state_d = StMult;
            StMult:   state_d = bus.abort ? StIdle : StAccum;
            StAccum:  state_d = bus.abort ? StIdle : StUpdate;
            StUpdate: begin
                // abort outranks the escape/limit decision
                if (bus.abort)              state_d = StIdle;
                else if (escape || limit)   state_d = StHold;
                else                        state_d = StMult;
            end
            StHold:   if (bus.out_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            x_q           <= '0;
            y_q           <= '0;
            max_iter_q    <= '0;
            depth_q       <= '0;
            re_c_q        <= '0;
            im_c_q        <= '0;
            re_q          <= '0;
            im_q          <= '0;
            re_nx_q       <= '0;
            im_nx_q       <= '0;
            rr_q          <= '0;
            ii_q          <= '0;
            ri_q          <= '0;
            mag_q         <= '0;
            out_valid_q   <= 1'b0;
            out_escaped_q <= 1'b0;
            out_x_q       <= '0;
            out_y_q       <= '0;
            out_depth_q   <= '0;
        end else begin
            if (accept) begin
                x_q        <= bus.in_x;
                y_q        <= bus.in_y;
                re_c_q     <= bus.re_c;
                im_c_q     <= bus.im_c;
                max_iter_q <= bus.max_iter;
                re_q       <= bus.julia_mode ? bus.re_z0 : '0;
                im_q       <= bus.julia_mode ? bus.im_z0 : '0;
                depth_q    <= '0;
            end
            if (state_q == StMult) begin
                rr_q <= re_ext * re_ext;
                ii_q <= im_ext * im_ext;
                ri_q <= re_ext * im_ext;
            end
            if (state_q == StAccum) begin
                mag_q   <= MW'(rr_q) + MW'(ii_q);
                re_nx_q <= WORD_LENGTH'(re_sum);
                im_nx_q <= WORD_LENGTH'(im_sum);
            end
            if (state_q == StUpdate && !bus.abort) begin
                if (escape || limit) begin
                    out_valid_q   <= 1'b1;
                    out_escaped_q <= escape;
                    out_x_q       <= x_q;
                    out_y_q       <= y_q;
                    out_depth_q   <= depth_q;
                end else begin
                    re_q    <= re_nx_q;
                    im_q    <= im_nx_q;
                    depth_q <= depth_q + ITER_W'(1);
                end
            end
            if (state_q == StHold && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_escaped = out_escaped_q;
    assign bus.out_x       = out_x_q;
    assign bus.out_y       = out_y_q;
    assign bus.out_depth   = out_depth_q;

endmodule

// File: tb/tb_mandel_depth_engine.sv
// Bench for mandel_depth_engine: directed cases plus randomized jobs, every cycle
// compared against a behavioural escape-time model with a result scoreboard.
module tb_mandel_depth_engine;
    localparam int unsigned WL = 32;
    localparam int unsigned FR = 28;
    localparam int unsigned IW = 11;
    localparam int ONE = 32'h1000_0000;

    logic sysclk = 1'b0;
    logic reset_n = 1'b0;
    always #5 sysclk = ~sysclk;

    mandel_depth_engine_if #(.WORD_LENGTH(WL), .ITER_W(IW)) bus ();

    mandel_depth_engine #(.WORD_LENGTH(WL), .FRAC(FR), .ITER_W(IW)) dut (
        .sysclk (sysclk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s at cycle %0d: got %0d, expected %0d",
                                       name, cyc, act, exp);
        end
    endtask

    // Escape-time iteration straight from the arithmetic rules, on 64-bit integers.
    function automatic void model(input int cr, input int ci, input int zr0, input int zi0,
                                  input bit julia, input int mi,
                                  output int depth, output bit esc);
        int zr, zi;
        longint a, b, p;
        bit done;
        zr = julia ? zr0 : 0;
        zi = julia ? zi0 : 0;
        depth = 0;
        esc = 1'b0;
        done = 1'b0;
        while (!done) begin
            a = longint'(zr) * longint'(zr);
            b = longint'(zi) * longint'(zi);
            p = longint'(zr) * longint'(zi);
            if (a > (longint'(1) <<< 58) - b) begin
                esc = 1'b1;
                done = 1'b1;
            end else if (depth == mi) begin
                done = 1'b1;
            end else begin
                zr = int'((a >>> FR) - (b >>> FR) + longint'(cr));
                zi = int'((p >>> (FR - 1)) + longint'(ci));
                depth++;
            end
        end
    endfunction

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        int          depth;
        logic        esc;
        int          due;
    } res_t;

    res_t exp_q[$];
    res_t last;
    bit   idle;

    // Per-cycle compare against the scoreboard; also advances the model's job state.
    always @(negedge sysclk) begin
        bit   ev;
        res_t r;
        int   d;
        bit   e;
        if (!reset_n) begin
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_in_ready", bus.in_ready, 0);
            chk("rst_out_depth", bus.out_depth, 0);
            chk("rst_out_escaped", bus.out_escaped, 0);
            chk("rst_out_xy", {bus.out_x, bus.out_y}, 0);
            exp_q.delete();
            last = '0;
            idle = 1'b1;
        end else begin
            ev = (exp_q.size() > 0) && (cyc >= exp_q[0].due);
            chk("in_ready", bus.in_ready, idle);
            chk("out_valid", bus.out_valid, ev);
            r = ev ? exp_q[0] : last;
            chk("out_x", bus.out_x, r.x);
            chk("out_y", bus.out_y, r.y);
            chk("out_depth", bus.out_depth, r.depth);
            chk("out_escaped", bus.out_escaped, r.esc);
            if (idle && bus.in_valid) begin
                model(bus.re_c, bus.im_c, bus.re_z0, bus.im_z0, bus.julia_mode,
                      int'(bus.max_iter), d, e);
                r.x = bus.in_x;
                r.y = bus.in_y;
                r.depth = d;
                r.esc = e;
                r.due = cyc + 4 + 3 * d;
                exp_q.push_back(r);
                idle = 1'b0;
            end else if (exp_q.size() > 0 && !ev && bus.abort) begin
                void'(exp_q.pop_front());
                idle = 1'b1;
            end else if (ev && bus.out_ready) begin
                last = exp_q.pop_front();
                idle = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic scramble();
        bus.in_x = 11'($urandom);
        bus.in_y = 11'($urandom);
        bus.re_c = $urandom;
        bus.im_c = $urandom;
        bus.re_z0 = $urandom;
        bus.im_z0 = $urandom;
        bus.julia_mode = 1'($urandom);
        bus.max_iter = 11'($urandom);
    endtask

    task automatic send(input logic [10:0] x, input logic [10:0] y, input int cr, input int ci,
                        input int zr, input int zi, input bit j, input int mi, output int acc);
        bus.in_valid = 1'b1;
        bus.in_x = x;
        bus.in_y = y;
        bus.re_c = cr;
        bus.im_c = ci;
        bus.re_z0 = zr;
        bus.im_z0 = zi;
        bus.julia_mode = j;
        bus.max_iter = 11'(mi);
        acc = -1;
        for (int n = 0; n < 400 && acc < 0; n++) begin
            @(negedge sysclk);
            if (bus.in_ready) acc = cyc;
            tick();
        end
        bus.in_valid = 1'b0;
        scramble();
        if (acc < 0) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_result(input int acc, output int depth, output bit esc, output int lat,
                               output logic [10:0] ox, output logic [10:0] oy);
        lat = -1;
        depth = -1;
        esc = 1'b0;
        ox = '0;
        oy = '0;
        for (int n = 0; n < 1000 && lat < 0; n++) begin
            @(negedge sysclk);
            if (bus.out_valid) begin
                lat = cyc - acc;
                depth = int'(bus.out_depth);
                esc = bus.out_escaped;
                ox = bus.out_x;
                oy = bus.out_y;
            end
        end
        if (lat < 0) chk("result_timeout", 0, 1);
        tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, lat, acc;
        bit e, done;
        logic [10:0] ox, oy;
        int cr, ci, zr, zi;

        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.abort = 1'b0;
        scramble();
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;

        // Pin the model to hand-derived results.
        model(ONE, 0, 0, 0, 1'b0, 100, d, e);
        chk("model_c1_depth", d, 3);
        chk("model_c1_esc", e, 1);
        model(0, 0, 0, 0, 1'b0, 100, d, e);
        chk("model_c0_depth", d, 100);
        chk("model_c0_esc", e, 0);
        model(32'hE000_0000, 0, 0, 0, 1'b0, 50, d, e);
        chk("model_cm2_depth", d, 50);
        chk("model_cm2_esc", e, 0);
        model(0, 0, 3 * ONE, 0, 1'b1, 10, d, e);
        chk("model_julia3_depth", d, 0);
        chk("model_julia3_esc", e, 1);

        // c = 1.0: z 0,1,2,5
        send(11'd5, 11'd6, ONE, 0, 0, 0, 1'b0, 100, acc);
        wait_result(acc, d, e, lat, ox, oy);
        chk("c1_depth", d, 3);
        chk("c1_esc", e, 1);
        chk("c1_latency", lat, 13);

        // c = 0 never escapes
        send(11'd1, 11'd2, 0, 0, 0, 0, 1'b0, 100, acc);
        wait_result(acc, d, e, lat, ox, oy);
        chk("c0_depth", d, 100);
        chk("c0_esc", e, 0);
        chk("c0_latency", lat, 304);

        // c = -2.0 sits exactly on |z|^2 = 4.0
        send(11'd3, 11'd4, 32'hE000_0000, 0, 0, 0, 1'b0, 50, acc);
        wait_result(acc, d, e, lat, ox, oy);
        chk("cm2_depth", d, 50);
        chk("cm2_esc", e, 0);
        chk("cm2_latency", lat, 154);

        // Julia start outside the radius escapes before any update
        send(11'd37, 11'd901, 0, 0, 3 * ONE, 0, 1'b1, 10, acc);
        wait_result(acc, d, e, lat, ox, oy);
        chk("julia_depth", d, 0);
        chk("julia_esc", e, 1);
        chk("julia_latency", lat, 4);
        chk("julia_x", ox, 37);
        chk("julia_y", oy, 901);

        // Back-pressure: result held for 5 cycles
        bus.out_ready = 1'b0;
        send(11'd9, 11'd10, ONE, 0, 0, 0, 1'b0, 100, acc);
        wait_result(acc, d, e, lat, ox, oy);
        for (int i = 0; i < 4; i++) begin
            @(negedge sysclk);
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_in_ready", bus.in_ready, 0);
            chk("hold_depth", bus.out_depth, 3);
            chk("hold_x", bus.out_x, 9);
            tick();
        end
        bus.out_ready = 1'b1;
        @(negedge sysclk);
        chk("hs_cycle_in_ready", bus.in_ready, 0);
        tick();
        @(negedge sysclk);
        chk("after_hs_in_ready", bus.in_ready, 1);
        chk("after_hs_valid", bus.out_valid, 0);
        chk("after_hs_depth_kept", bus.out_depth, 3);
        tick();

        // Abort at T+2, then reset in the middle of a second job
        send(11'd11, 11'd12, 0, 0, 0, 0, 1'b0, 100, acc);
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sysclk);
            chk("abort_no_valid", bus.out_valid, 0);
            tick();
        end
        send(11'd13, 11'd14, 0, 0, 0, 0, 1'b0, 100, acc);
        repeat (5) tick();
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge sysclk);
            chk("post_rst_no_valid", bus.out_valid, 0);
            tick();
        end
        send(11'd15, 11'd16, ONE, 0, 0, 0, 1'b0, 100, acc);
        wait_result(acc, d, e, lat, ox, oy);
        chk("post_rst_depth", d, 3);
        chk("post_rst_esc", e, 1);
        chk("post_rst_latency", lat, 13);

        // Randomized jobs with random back-pressure and occasional aborts
        for (int j = 0; j < 60; j++) begin
            if ($urandom_range(7, 0) == 0) begin
                cr = $urandom;
                ci = $urandom;
            end else begin
                cr = int'($urandom_range(32'h3FFF_FFFF, 0)) - 32'sh2000_0000;
                ci = int'($urandom_range(32'h3FFF_FFFF, 0)) - 32'sh2000_0000;
            end
            zr = int'($urandom_range(32'h3FFF_FFFF, 0)) - 32'sh2000_0000;
            zi = int'($urandom_range(32'h3FFF_FFFF, 0)) - 32'sh2000_0000;
            send(11'($urandom), 11'($urandom), cr, ci, zr, zi, 1'($urandom),
                 int'($urandom_range(40, 0)), acc);
            done = 1'b0;
            for (int n = 0; n < 600 && !done; n++) begin
                bus.out_ready = ($urandom_range(3, 0) != 0);
                bus.abort = ($urandom_range(63, 0) == 0);
                @(negedge sysclk);
                done = bus.in_ready;
                tick();
            end
            if (!done) chk("idle_timeout", 0, 1);
            bus.abort = 1'b0;
            bus.out_ready = 1'b1;
        end

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
